reaction_ctrl: RTL

//  Trial controller for the reaction timer; sits between the LFSR and the Down_Counter.
//  On start it takes the LFSR value as a random delay in ms and loads it into the down counter.
//  It decrements the counter once per ms, then lights the GO LED.
//  It measures the player's press latency in ms and reports a result, a foul (early press) or a timeout.

---
 rtl/reaction_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/reaction_ctrl.sv
// Reaction-timer trial controller.
// Loads a floored random delay into the external down counter, counts it down
// one step per millisecond, lights GO, then times the player's press in ms.
// An early press ends the trial as a foul; no press by TIMEOUT_MS ends it as a timeout.
module reaction_ctrl #(
  parameter int CLK_PER_MS   = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int TIMEOUT_MS   = 9999,
  parameter int RT_W         = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            button,
  input  logic [11:0]     lfsr_val,
  input  logic [11:0]     cnt_val,
  output logic            lfsr_e,
  output logic            cnt_load,
  output logic [11:0]     cnt_d,
  output logic            cnt_e,
  output logic            led_go,
  output logic            busy,
  output logic [RT_W-1:0] result,
  output logic            result_valid,
  output logic            foul,
  output logic            timeout
);

  localparam int PW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [RT_W-1:0] RT_MAX     = RT_W'(TIMEOUT_MS);
  localparam logic [11:0]     DELAY_MIN  = 12'(MIN_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_GO, S_DONE, S_FOUL
  } state_t;

  state_t          state_q, state_d;
  logic            btn_q;
  logic [PW-1:0]   prescCnt_q, prescCnt_d;
  logic [RT_W-1:0] rxnCnt_q, rxnCnt_d;
  logic [RT_W-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic            foul_q, foul_d;
  logic            timeout_q, timeout_d;

  logic press;
  logic tick;
  logic enterWait;
  logic enterGo;

  // A press is only the rising edge, so a button already held when the trial starts is ignored.
  assign press     = button & ~btn_q;
  assign tick      = (prescCnt_q == PRESC_LAST);
  assign enterWait = (state_d == S_WAIT) && (state_q != S_WAIT);
  assign enterGo   = (state_d == S_GO) && (state_q != S_GO);

  // State register plus the button history used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= button;
    end
  end

  // Trial sequencing; press beats both the counter reaching zero and the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_FOUL: if (start) state_d = S_ARM;
      S_ARM:                  state_d = S_WAIT;
      S_WAIT: begin
        if (press)              state_d = S_FOUL;
        else if (cnt_val == '0) state_d = S_GO;
      end
      S_GO: if (press || (rxnCnt_q == RT_MAX)) state_d = S_DONE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Next values for the ms prescaler, reaction counter and the held result/flags.
  always_comb begin
    prescCnt_d = prescCnt_q + 1'b1;
    rxnCnt_d   = rxnCnt_q;
    result_d   = result_q;
    valid_d    = valid_q;
    foul_d     = foul_q;
    timeout_d  = timeout_q;

    if (enterWait || enterGo || tick) prescCnt_d = '0;

    if (enterGo)
      rxnCnt_d = '0;
    else if ((state_q == S_GO) && tick && (rxnCnt_q < RT_MAX))
      rxnCnt_d = rxnCnt_q + 1'b1;

    if (state_d == S_ARM && state_q != S_ARM) begin
      valid_d   = 1'b0;
      foul_d    = 1'b0;
      timeout_d = 1'b0;
    end else if (state_q == S_WAIT && press) begin
      foul_d = 1'b1;
    end else if (state_q == S_GO) begin
      if (press) begin
        result_d  = rxnCnt_q;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
      end else if (rxnCnt_q == RT_MAX) begin
        result_d  = RT_MAX;
        valid_d   = 1'b1;
        timeout_d = 1'b1;
      end
    end
  end

  // Datapath registers; reset discards any partially measured trial.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescCnt_q <= '0;
      rxnCnt_q   <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      foul_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      prescCnt_q <= prescCnt_d;
      rxnCnt_q   <= rxnCnt_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      foul_q     <= foul_d;
      timeout_q  <= timeout_d;
    end
  end

  // Moore output decode; the LFSR runs whenever we are waiting on the player to start.
  always_comb begin
    lfsr_e       = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FOUL);
    cnt_load     = (state_q == S_ARM);
    cnt_d        = (lfsr_val < DELAY_MIN) ? DELAY_MIN : lfsr_val;
    cnt_e        = (state_q == S_WAIT) && tick && (cnt_val != '0);
    led_go       = (state_q == S_GO);
    busy         = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_GO);
    result       = result_q;
    result_valid = valid_q;
    foul         = foul_q;
    timeout      = timeout_q;
  end

endmodule
